mmio_slot_arbiter: RTL and testbench
====================================

# mmio_slot_arbiter

Shares one MMIO slot (the chip_select/read/write/addr/wr_data bus with wr_done/rd_done/slave_error/decode_error/transaction_completed handshake used by gpio and the other slot peripherals) between NUM_MASTERS requesters. It grants requesters round-robin and runs one slot transaction at a time. It captures the slot response, closes each transaction with a one-cycle transaction_completed pulse, and aborts hung transactions with a timeout error. It sits between the MMIO address decoder and a single slot peripheral.

## Interface
- NUM_MASTERS, 2: number of requesters, 2..8.
- TIMEOUT_CYCLES, 16: maximum cycles in ISSUE before abort, ≥4.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_MASTERS  per-master request; held high until the matching req_ready bit.
- req_write  input  NUM_MASTERS  per-master direction: 1 = write, 0 = read.
- req_addr  input  8*NUM_MASTERS  per-master address; master i occupies [8i+7:8i].
- req_wdata  input  32*NUM_MASTERS  per-master write data; master i occupies [32i+31:32i].
- req_ready  output  NUM_MASTERS  one-hot, one-cycle grant pulse.
- resp_valid  output  NUM_MASTERS  one-hot, one-cycle response pulse to the granted master.
- resp_rdata  output  32  read data, valid with resp_valid.
- resp_slave_error, resp_decode_error, resp_timeout  output  1 each  response status, valid with resp_valid.
- chip_select, read, write  output  1 each  slot controls.
- addr  output  8  slot address.
- wr_data  output  32  slot write data.
- transaction_completed  output  1  slot close pulse.
- rd_data  input  32  slot read data.
- wr_done, rd_done, slave_error, decode_error  input  1 each  slot status.

## Operation
- FSM states:
  - IDLE: if any req_valid bit is set, pick the winner, pulse req_ready for it, latch write/addr/wdata into internal registers, clear the timeout counter, and go to ISSUE.
  - ISSUE: drive chip_select=1, read=~write_q, write=write_q, addr=addr_q, wr_data=wdata_q. Each cycle, check for completion, which is wr_done | rd_done | slave_error | decode_error. On completion, capture rd_data and the error bits, then go to COMPLETE. Otherwise increment the counter. When the counter equals TIMEOUT_CYCLES-1 with no completion, set timeout_q and go to COMPLETE.
  - COMPLETE: chip_select, read and write are 0. Pulse transaction_completed=1 and resp_valid[grant]=1 for this one cycle, then go to IDLE.
- Round-robin arbitration:
  - Search starts at last_grant+1 and wraps modulo NUM_MASTERS.
  - last_grant updates only on grant.
  - Reset sets last_grant=NUM_MASTERS-1, so master 0 has first priority.
- The captured rd_data is the value present on the completion cycle. The slot zeroes rd_data afterwards, so later values are never used. rd_data is captured only for reads; the write response reports 0.
- Errors are passed through as captured. A write that gets both wr_done and slave_error returns resp_slave_error=1. A decode_error without a done signal still counts as completion.
- If done and timeout occur on the same cycle, done wins and resp_timeout=0.
- Slot outputs addr and wr_data stay at their latched values outside ISSUE. They are don't-care while chip_select=0.
- A requester dropping req_valid before grant is a protocol violation. No behaviour is required.

## Timing
- Reset: FSM=IDLE, and every output is 0, including all status outputs, resp_rdata and transaction_completed. Internal registers are cleared. Reset in any state aborts the transaction with no resp_valid. transaction_completed is not issued.
- Nominal gpio read or write with the grant at cycle T:
  - T: req_ready.
  - T+1..T+3: ISSUE, chip_select high.
  - T+3: done seen.
  - T+4: COMPLETE, with resp_valid and transaction_completed.
  - T+5: IDLE, next grant possible, so at best one transaction every 5 cycles.
- Timeout with the grant at T: COMPLETE occurs at T+1+TIMEOUT_CYCLES.
- chip_select falls in the same cycle transaction_completed rises. This prevents the slot from restarting when it returns to IDLE.
- No combinational path from slot inputs to slot outputs or resp outputs. All outputs are registered or decoded from FSM state.

## Test plan
- Single read: master0 reads addr 0x10, slot returns rd_done=1 and rd_data=0x1 at T+3. Required: req_ready[0] at T, resp_valid[0] with resp_rdata=0x1 and no errors at T+4, transaction_completed at T+4 only.
- Write to read-only register: master1 writes 0x14 with data 0xF, slot returns wr_done=1 and slave_error=1. Required: resp_valid[1], resp_slave_error=1, resp_rdata=0, write=1 throughout ISSUE.
- Decode error: read of addr 0x40, slot raises only decode_error. Required: completion accepted, resp_decode_error=1, resp_valid on the next cycle.
- Round-robin with NUM_MASTERS=3: all masters request continuously from reset. Required: grant order 0,1,2,0 at 5-cycle spacing. A second check: master2 alone, then masters 0 and 2 together. Required: 0 is granted before 2.
- Timeout with TIMEOUT_CYCLES=16: the slot never responds. Required: resp_timeout=1 and transaction_completed at T+17. The next request then completes normally. A variant raises done on the final counted cycle. Required: resp_timeout=0.
- Reset mid-transaction: assert rst during ISSUE. Required: all outputs 0 on the next cycle, no resp_valid, and master 0 has priority after release.

Source files
------------

// File: rtl/mmio_slot_arbiter.sv
// Round-robin arbiter sharing one MMIO slot between NUM_MASTERS requesters.
// Runs one slot transaction at a time, with a timeout abort for hung slots.
module mmio_slot_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_MASTERS-1:0]    req_valid_i,
  input  logic [NUM_MASTERS-1:0]    req_write_i,
  input  logic [8*NUM_MASTERS-1:0]  req_addr_i,
  input  logic [32*NUM_MASTERS-1:0] req_wdata_i,
  output logic [NUM_MASTERS-1:0]    req_ready_o,
  output logic [NUM_MASTERS-1:0]    resp_valid_o,
  output logic [31:0]               resp_rdata_o,
  output logic                      resp_slave_error_o,
  output logic                      resp_decode_error_o,
  output logic                      resp_timeout_o,
  output logic                      chip_select_o,
  output logic                      read_o,
  output logic                      write_o,
  output logic [7:0]                addr_o,
  output logic [31:0]               wr_data_o,
  output logic                      transaction_completed_o,
  input  logic [31:0]               rd_data_i,
  input  logic                      wr_done_i,
  input  logic                      rd_done_i,
  input  logic                      slave_error_i,
  input  logic                      decode_error_i
);

  localparam int IDXW = $clog2(NUM_MASTERS);
  localparam int CNTW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  state_e                  state_q;
  logic [IDXW-1:0]         last_grant_q;
  logic [IDXW-1:0]         grant_q;
  logic [CNTW-1:0]         cnt_q;
  logic                    cs_q;
  logic                    rd_q;
  logic                    wr_q;
  logic [7:0]              addr_q;
  logic [31:0]             wdata_q;
  logic [NUM_MASTERS-1:0]  resp_valid_q;
  logic [31:0]             rdata_q;
  logic                    slv_err_q;
  logic                    dec_err_q;
  logic                    timeout_q;
  logic                    tc_q;

  logic                    win_found;
  logic [IDXW-1:0]         win_idx;
  logic                    slot_done;

  // Search starts one past the last grant and wraps, first requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!win_found && req_valid_i[(int'(last_grant_q) + k) % NUM_MASTERS]) begin
        win_found = 1'b1;
        win_idx   = IDXW'((int'(last_grant_q) + k) % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (!rst_i && state_q == ST_IDLE && win_found) req_ready_o[win_idx] = 1'b1;
  end

  assign slot_done = wr_done_i | rd_done_i | slave_error_i | decode_error_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_IDX;
      grant_q      <= '0;
      cnt_q        <= '0;
      cs_q         <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= '0;
      rdata_q      <= '0;
      slv_err_q    <= 1'b0;
      dec_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      tc_q         <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      tc_q         <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            grant_q      <= win_idx;
            last_grant_q <= win_idx;
            addr_q       <= req_addr_i[8*int'(win_idx) +: 8];
            wdata_q      <= req_wdata_i[32*int'(win_idx) +: 32];
            rd_q         <= ~req_write_i[win_idx];
            wr_q         <= req_write_i[win_idx];
            cs_q         <= 1'b1;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A done on the last counted cycle takes precedence over the timeout.
          if (slot_done || cnt_q == CNT_LAST) begin
            if (slot_done) begin
              rdata_q   <= wr_q ? 32'd0 : rd_data_i;
              slv_err_q <= slave_error_i;
              dec_err_q <= decode_error_i;
              timeout_q <= 1'b0;
            end else begin
              rdata_q   <= 32'd0;
              slv_err_q <= 1'b0;
              dec_err_q <= 1'b0;
              timeout_q <= 1'b1;
            end
            cs_q                  <= 1'b0;
            rd_q                  <= 1'b0;
            wr_q                  <= 1'b0;
            tc_q                  <= 1'b1;
            resp_valid_q[grant_q] <= 1'b1;
            state_q               <= ST_COMPLETE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_COMPLETE: state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid_o            = resp_valid_q;
  assign resp_rdata_o            = rdata_q;
  assign resp_slave_error_o      = slv_err_q;
  assign resp_decode_error_o     = dec_err_q;
  assign resp_timeout_o          = timeout_q;
  assign chip_select_o           = cs_q;
  assign read_o                  = rd_q;
  assign write_o                 = wr_q;
  assign addr_o                  = addr_q;
  assign wr_data_o               = wdata_q;
  assign transaction_completed_o = tc_q;

endmodule

// File: tb/tb_mmio_slot_arbiter.sv
// Directed bench for mmio_slot_arbiter: a responding slot model plus a
// response scoreboard filled at grant time and drained by a monitor.
module tb_mmio_slot_arbiter;

  localparam int NM = 3;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     req_valid;
  logic [NM-1:0]     req_write;
  logic [8*NM-1:0]   req_addr;
  logic [32*NM-1:0]  req_wdata;
  logic [NM-1:0]     req_ready;
  logic [NM-1:0]     resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_slave_error, resp_decode_error, resp_timeout;
  logic              chip_select, read, write;
  logic [7:0]        addr;
  logic [31:0]       wr_data;
  logic              transaction_completed;
  logic [31:0]       rd_data;
  logic              wr_done, rd_done, slave_error, decode_error;

  mmio_slot_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid),
    .resp_rdata_o(resp_rdata), .resp_slave_error_o(resp_slave_error),
    .resp_decode_error_o(resp_decode_error), .resp_timeout_o(resp_timeout),
    .chip_select_o(chip_select), .read_o(read), .write_o(write),
    .addr_o(addr), .wr_data_o(wr_data),
    .transaction_completed_o(transaction_completed),
    .rd_data_i(rd_data), .wr_done_i(wr_done), .rd_done_i(rd_done),
    .slave_error_i(slave_error), .decode_error_i(decode_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        slv;
    logic        dec;
    logic        tout;
    int          at;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // slot model configuration
  int          slot_delay = 3;
  logic        cfg_done   = 1'b1;
  logic        cfg_slv    = 1'b0;
  logic        cfg_dec    = 1'b0;
  logic [31:0] cfg_rdata  = 32'd0;
  logic        cur_wr     = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Slot: responds on the slot_delay-th chip_select cycle, zero otherwise.
  initial begin
    int cs_cnt;
    cs_cnt = 0;
    wr_done = 1'b0; rd_done = 1'b0; slave_error = 1'b0; decode_error = 1'b0;
    rd_data = 32'd0;
    forever begin
      @(negedge clk);
      if (chip_select === 1'b1) cs_cnt++;
      else cs_cnt = 0;
      if (chip_select === 1'b1 && cs_cnt == slot_delay) begin
        wr_done      = cfg_done & write;
        rd_done      = cfg_done & read;
        slave_error  = cfg_slv;
        decode_error = cfg_dec;
        rd_data      = cfg_rdata;
      end else begin
        wr_done = 1'b0; rd_done = 1'b0; slave_error = 1'b0; decode_error = 1'b0;
        rd_data = 32'd0;
      end
    end
  end

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (chip_select === 1'b1) begin
          chk("issue_write", write, cur_wr);
          chk("issue_read", read, !cur_wr);
        end
        if (resp_valid !== '0) begin
          if (sbq.size() == 0) begin
            chk("unexpected_resp", resp_valid, 0);
          end else begin
            e = sbq.pop_front();
            chk("resp_valid", resp_valid, 1 << e.m);
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_slave_error", resp_slave_error, e.slv);
            chk("resp_decode_error", resp_decode_error, e.dec);
            chk("resp_timeout", resp_timeout, e.tout);
            chk("resp_cycle", cyc, e.at);
            chk("tc_with_resp", transaction_completed, 1);
            chk("cs_low_at_complete", chip_select, 0);
          end
        end else begin
          chk("tc_without_resp", transaction_completed, 0);
        end
      end
    end
  end

  task automatic set_req(input int m, input logic wr, input logic [7:0] a, input logic [31:0] d);
    req_valid[m]          = 1'b1;
    req_write[m]          = wr;
    req_addr[8*m +: 8]    = a;
    req_wdata[32*m +: 32] = d;
  endtask

  // Waits for master m's grant, optionally queues its response expected at T+off.
  task automatic wait_grant(input int m, input bit push, input int off,
                            input logic [31:0] erd, input logic eslv,
                            input logic edec, input logic etout,
                            input bit drop, output int t);
    t = -1;
    #1;
    for (int b = 0; b < 60 && req_ready == '0; b++) begin
      @(negedge clk);
      #1;
    end
    chk("req_ready", req_ready, 1 << m);
    if (req_ready != '0) begin
      t = cyc;
      if (push) sbq.push_back(exp_t'{m, erd, eslv, edec, etout, t + off});
    end
    @(negedge clk);
    if (drop) req_valid[m] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int b = 0; b < 40 && sbq.size() != 0; b++) @(negedge clk);
    chk("drain", sbq.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_slot"}, {chip_select, read, write, addr, wr_data, transaction_completed}, 0);
    chk({tag, "_resp"}, {req_ready, resp_valid, resp_rdata, resp_slave_error,
                         resp_decode_error, resp_timeout}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3;
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // single read
    cur_wr = 1'b0; slot_delay = 3; cfg_done = 1'b1; cfg_rdata = 32'h1;
    set_req(0, 1'b0, 8'h10, 32'h0);
    wait_grant(0, 1'b1, 4, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    chk("read_addr", addr, 8'h10);
    wait_drain();

    // write to read-only register: done plus slave error, write reports no data
    cur_wr = 1'b1; cfg_slv = 1'b1; cfg_rdata = 32'hDEAD_BEEF;
    set_req(1, 1'b1, 8'h14, 32'hF);
    wait_grant(1, 1'b1, 4, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, t0);
    chk("write_addr", addr, 8'h14);
    chk("write_data", wr_data, 32'hF);
    wait_drain();

    // decode error alone completes the transaction
    cur_wr = 1'b0; cfg_done = 1'b0; cfg_slv = 1'b0; cfg_dec = 1'b1; cfg_rdata = 32'h0;
    set_req(2, 1'b0, 8'h40, 32'h0);
    wait_grant(2, 1'b1, 4, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, t0);
    wait_drain();

    // hung slot times out, then a normal read
    cfg_done = 1'b1; cfg_dec = 1'b0; slot_delay = 0;
    set_req(0, 1'b0, 8'h20, 32'h0);
    wait_grant(0, 1'b1, TO + 1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, t0);
    wait_drain();
    slot_delay = 3; cfg_rdata = 32'h55;
    set_req(1, 1'b0, 8'h24, 32'h0);
    wait_grant(1, 1'b1, 4, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    wait_drain();

    // done on the last counted cycle beats the timeout
    slot_delay = TO; cfg_rdata = 32'h77;
    set_req(2, 1'b0, 8'h28, 32'h0);
    wait_grant(2, 1'b1, TO + 1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    wait_drain();

    // master 2 alone, then 0 and 2 together: 0 goes first
    slot_delay = 3; cfg_rdata = 32'h3;
    set_req(2, 1'b0, 8'h30, 32'h0);
    wait_grant(2, 1'b1, 4, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    wait_drain();
    set_req(0, 1'b0, 8'h31, 32'h0);
    set_req(2, 1'b0, 8'h32, 32'h0);
    wait_grant(0, 1'b1, 4, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    wait_grant(2, 1'b1, 4, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, t2);
    chk("rr_pair_spacing", t2 - t0, 5);
    wait_drain();

    // all masters requesting continuously from reset
    rst = 1'b1;
    set_req(0, 1'b0, 8'h50, 32'h0);
    set_req(1, 1'b0, 8'h51, 32'h0);
    set_req(2, 1'b0, 8'h52, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("ready_in_reset", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_grant(0, 1'b1, 4, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    wait_grant(1, 1'b1, 4, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, t1);
    wait_grant(2, 1'b1, 4, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, t2);
    wait_grant(0, 1'b1, 4, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, t3);
    req_valid = '0;
    chk("rr_spacing_01", t1 - t0, 5);
    chk("rr_spacing_12", t2 - t1, 5);
    chk("rr_spacing_20", t3 - t2, 5);
    wait_drain();

    // reset during ISSUE aborts silently and restores master 0 priority
    set_req(0, 1'b0, 8'h60, 32'h0);
    wait_grant(0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    set_req(0, 1'b0, 8'h61, 32'h0);
    set_req(1, 1'b0, 8'h62, 32'h0);
    wait_grant(0, 1'b1, 4, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    wait_grant(1, 1'b1, 4, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, t1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
